// File: rtl/sram_sched_pkg.sv
// Shared types and default widths for the SRAM read/write scheduler.
package sram_sched_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin arbiter. The candidate is always visible so the
// parent can check it for conflicts and hold the grant back with 'block'.
module sram_rr_arb2 (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       block,
    output logic       cand_idx,
    output logic [1:0] gnt
);

    logic prio_q;
    logic grant_en;

    // Candidate is the priority requester if it asks, otherwise the other one
    always_comb begin
        cand_idx = req[prio_q] ? prio_q : ~prio_q;
        grant_en = (|req) && !block;
        gnt      = grant_en ? {cand_idx, ~cand_idx} : 2'b00;
    end

    // After a grant the other requester gets priority; blocked cycles leave it alone
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (grant_en) begin
            prio_q <= ~cand_idx;
        end
    end

endmodule

// File: rtl/sram_rw_scheduler.sv
// Scheduler for a 1W/1R SRAM macro: clears the array after reset, then
// passes writes straight through and round-robins two read requesters.
// Optional feature: define SRAM_SCHED_FWD_EN to forward write data to a
// same-address read instead of stalling that read for a cycle.
module sram_rw_scheduler
    import sram_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                    clk0,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    input  logic [1:0]              rd_valid,
    input  logic [2*ADDR_WIDTH-1:0] rd_addr,
    output logic [1:0]              rd_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic                    init_done,
    output logic                    csb0,
    output logic [ADDR_WIDTH-1:0]   addr0,
    output logic [DATA_WIDTH-1:0]   din0,
    output logic                    csb1,
    output logic [ADDR_WIDTH-1:0]   addr1,
    input  logic [DATA_WIDTH-1:0]   dout1
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    sched_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic                    run, in_init, wr_acc;
    logic                    cand_idx, rd_block, rd_grant, addr_match;
    logic [ADDR_WIDTH-1:0]   cand_addr;
    logic [1:0]              s1_valid_q;

    // State and clear-address registers
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Walk the clear address up to the top of the array, then stay in RUN
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == ADDR_MAX) begin
                    state_d = RUN;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Reset is folded in so the SRAM port stays idle while rst_n is low
    assign run     = rst_n && (state_q == RUN);
    assign in_init = rst_n && (state_q == INIT);
    assign wr_ready = run;
    assign wr_acc   = run && wr_valid;

    // Write port: zero-fill during INIT, otherwise pass accepted writes through
    always_comb begin
        csb0  = 1'b1;
        addr0 = '0;
        din0  = '0;
        if (in_init) begin
            csb0  = 1'b0;
            addr0 = init_cnt_q;
        end else if (wr_acc) begin
            csb0  = 1'b0;
            addr0 = wr_addr;
            din0  = wr_data;
        end
    end

    assign cand_addr  = cand_idx ? rd_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : rd_addr[ADDR_WIDTH-1:0];
    assign addr_match = wr_acc && (cand_addr == wr_addr);

`ifdef SRAM_SCHED_FWD_EN
    assign rd_block = !run;
`else
    assign rd_block = !run || addr_match;
`endif

    sram_rr_arb2 u_arb (
        .clk0     (clk0),
        .rst_n    (rst_n),
        .req      (rd_valid),
        .block    (rd_block),
        .cand_idx (cand_idx),
        .gnt      (rd_ready)
    );

    assign rd_grant = |rd_ready;
    assign csb1     = !rd_grant;
    assign addr1    = rd_grant ? cand_addr : '0;

`ifdef SRAM_SCHED_FWD_EN
    logic                  s1_fwd_q;
    logic [DATA_WIDTH-1:0] s1_fwd_data_q;

    // Remember whether the granted read collided and which write data it should return
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            s1_fwd_q      <= 1'b0;
            s1_fwd_data_q <= '0;
        end else begin
            s1_fwd_q      <= rd_grant && addr_match;
            s1_fwd_data_q <= wr_data;
        end
    end
`endif

    // Two-stage response pipeline: SRAM reads on the negedge, data lands here next posedge
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            s1_valid_q <= 2'b00;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
        end else begin
            s1_valid_q <= rd_ready;
            rsp_valid  <= s1_valid_q;
            if (|s1_valid_q) begin
`ifdef SRAM_SCHED_FWD_EN
                rsp_data <= s1_fwd_q ? s1_fwd_data_q : dout1;
`else
                rsp_data <= dout1;
`endif
            end
        end
    end

    // Completion flag rises once RUN has been reached and sticks until reset
    always_ff @(posedge clk0) begin
        if (!rst_n) begin
            init_done <= 1'b0;
        end else if (state_q == RUN) begin
            init_done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_rw_scheduler.sv
// Directed bench for sram_rw_scheduler with a behavioural 1W/1R SRAM model
// (write on posedge, read address latched on posedge, data out on negedge).
module tb_sram_rw_scheduler;

    logic        clk0 = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic [1:0]  rd_valid;
    logic [17:0] rd_addr;
    logic [1:0]  rd_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        init_done;
    logic        csb0;
    logic [8:0]  addr0;
    logic [31:0] din0;
    logic        csb1;
    logic [8:0]  addr1;
    logic [31:0] dout1;

    int num_compared   = 0;
    int num_mismatched = 0;

    always #5 clk0 = ~clk0;

    sram_rw_scheduler #(.DATA_WIDTH(32), .ADDR_WIDTH(9)) dut (
        .clk0      (clk0),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .init_done (init_done),
        .csb0      (csb0),
        .addr0     (addr0),
        .din0      (din0),
        .csb1      (csb1),
        .addr1     (addr1),
        .dout1     (dout1)
    );

    // SRAM model; never-written words read back as a recognisable non-zero pattern
    logic [31:0] mem [0:511];
    bit   [511:0] written;
    bit           rd_pend;
    bit   [8:0]   rd_addr_lat;

    always @(posedge clk0) begin
        if (!csb0) begin
            mem[addr0]     <= din0;
            written[addr0] <= 1'b1;
        end
        rd_pend <= !csb1;
        if (!csb1) rd_addr_lat <= addr1;
    end

    always @(negedge clk0) begin
        if (rd_pend) dout1 <= written[rd_addr_lat] ? mem[rd_addr_lat] : (32'hBAD0_0000 | 32'(rd_addr_lat));
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [8:0] wa, input logic [31:0] wd,
                                 input logic [1:0] rv, input logic [8:0] ra0, input logic [8:0] ra1);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = {ra1, ra0};
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cnt;
        int grant_cnt;
        int resp_cnt;
        int stray_cnt;
        logic [31:0] or_data;
        logic [1:0] fair_exp [4];

        fair_exp[0] = 2'b01;
        fair_exp[1] = 2'b10;
        fair_exp[2] = 2'b01;
        fair_exp[3] = 2'b10;

        // Reset: outputs idle even with requests pending
        rst_n = 1'b0;
        applyStimulus(1'b1, 9'h005, 32'hFFFF_FFFF, 2'b11, 9'h001, 9'h002);
        tick();
        tick();
        checkOutput("rst_csb0", 64'(csb0), 64'd1);
        checkOutput("rst_csb1", 64'(csb1), 64'd1);
        checkOutput("rst_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("rst_rd_ready", 64'(rd_ready), 64'd0);
        checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        checkOutput("rst_init_done", 64'(init_done), 64'd0);

        // Release: first INIT cycle writes zero to address 0 and refuses requests
        rst_n = 1'b1;
        #1;
        checkOutput("init_wr_ready", 64'(wr_ready), 64'd0);
        checkOutput("init_rd_ready", 64'(rd_ready), 64'd0);
        checkOutput("init_csb0", 64'(csb0), 64'd0);
        checkOutput("init_addr0_first", 64'(addr0), 64'd0);
        checkOutput("init_din0", 64'(din0), 64'd0);
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);

        cnt = 0;
        while (!init_done && cnt < 1000) begin
            tick();
            cnt++;
            if (cnt == 1) checkOutput("init_addr0_step", 64'(addr0), 64'd1);
            if (cnt == 511) begin
                checkOutput("init_addr0_last", 64'(addr0), 64'd511);
                checkOutput("init_csb0_last", 64'(csb0), 64'd0);
            end
        end
        checkOutput("init_done_latency", 64'(cnt), 64'd513);

        // Read back every address from requester 0, one read per cycle
        grant_cnt = 0;
        resp_cnt  = 0;
        stray_cnt = 0;
        or_data   = 32'h0;
        for (int i = 0; i < 514; i++) begin
            applyStimulus(1'b0, 9'h0, 32'h0, (i < 512) ? 2'b01 : 2'b00, 9'(i), 9'h0);
            if (rd_ready == 2'b01) grant_cnt++;
            tick();
            if (rsp_valid == 2'b01) begin
                resp_cnt++;
                or_data = or_data | rsp_data;
            end else if (rsp_valid != 2'b00) begin
                stray_cnt++;
            end
        end
        checkOutput("readback_grants", 64'(grant_cnt), 64'd512);
        checkOutput("readback_responses", 64'(resp_cnt), 64'd512);
        checkOutput("readback_stray", 64'(stray_cnt), 64'd0);
        checkOutput("readback_or_data", 64'(or_data), 64'd0);

        // Write 0xDEADBEEF to 0x05, read it from requester 0 the next cycle
        applyStimulus(1'b1, 9'h005, 32'hDEAD_BEEF, 2'b00, 9'h0, 9'h0);
        checkOutput("wr_ready_run", 64'(wr_ready), 64'd1);
        checkOutput("wr_csb0", 64'(csb0), 64'd0);
        checkOutput("wr_addr0", 64'(addr0), 64'h005);
        checkOutput("wr_din0", 64'(din0), 64'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b01, 9'h005, 9'h0);
        checkOutput("rd_ready_r0", 64'(rd_ready), 64'b01);
        checkOutput("rd_csb1", 64'(csb1), 64'd0);
        checkOutput("rd_addr1", 64'(addr1), 64'h005);
        checkOutput("wr_idle_csb0", 64'(csb0), 64'd1);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        checkOutput("rsp_not_yet", 64'(rsp_valid), 64'b00);
        tick();
        checkOutput("rsp_valid_r0", 64'(rsp_valid), 64'b01);
        checkOutput("rsp_data_r0", 64'(rsp_data), 64'hDEAD_BEEF);
        tick();
        checkOutput("rsp_one_cycle", 64'(rsp_valid), 64'b00);
        checkOutput("rsp_data_hold", 64'(rsp_data), 64'hDEAD_BEEF);

        // Requester 1 read hands priority back to requester 0
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b10, 9'h0, 9'h005);
        checkOutput("rd_ready_r1", 64'(rd_ready), 64'b10);
        checkOutput("rd_addr1_r1", 64'(addr1), 64'h005);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        tick();
        checkOutput("rsp_valid_r1", 64'(rsp_valid), 64'b10);
        checkOutput("rsp_data_r1", 64'(rsp_data), 64'hDEAD_BEEF);
        tick();

        // Fairness: both requesters held for four cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 9'h0, 32'h0, 2'b11, 9'h005, 9'h006);
            checkOutput($sformatf("fair_grant_%0d", i), 64'(rd_ready), 64'(fair_exp[i]));
            tick();
        end
        checkOutput("fair_rsp2_valid", 64'(rsp_valid), 64'b01);
        checkOutput("fair_rsp2_data", 64'(rsp_data), 64'hDEAD_BEEF);
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        tick();
        checkOutput("fair_rsp3_valid", 64'(rsp_valid), 64'b10);
        checkOutput("fair_rsp3_data", 64'(rsp_data), 64'h0);
        tick();
        checkOutput("fair_drained", 64'(rsp_valid), 64'b00);

        // Collision: write and read of 0x1FF in the same cycle
        applyStimulus(1'b1, 9'h1FF, 32'h1234_5678, 2'b01, 9'h1FF, 9'h0);
        checkOutput("coll_csb0", 64'(csb0), 64'd0);
        checkOutput("coll_addr0", 64'(addr0), 64'h1FF);
`ifdef SRAM_SCHED_FWD_EN
        checkOutput("coll_rd_ready", 64'(rd_ready), 64'b01);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        tick();
`else
        checkOutput("coll_rd_ready", 64'(rd_ready), 64'b00);
        checkOutput("coll_csb1", 64'(csb1), 64'd1);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b11, 9'h1FF, 9'h010);
        checkOutput("coll_retry_rd_ready", 64'(rd_ready), 64'b01);
        checkOutput("coll_retry_addr1", 64'(addr1), 64'h1FF);
        tick();
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        tick();
`endif
        checkOutput("coll_rsp_valid", 64'(rsp_valid), 64'b01);
        checkOutput("coll_rsp_data", 64'(rsp_data), 64'h1234_5678);
        tick();

        // Reset one cycle after a grant: response is dropped and INIT restarts
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b01, 9'h005, 9'h0);
        checkOutput("midrst_grant", 64'(rd_ready), 64'b01);
        tick();
        rst_n = 1'b0;
        applyStimulus(1'b0, 9'h0, 32'h0, 2'b00, 9'h0, 9'h0);
        tick();
        checkOutput("midrst_rsp_valid", 64'(rsp_valid), 64'b00);
        checkOutput("midrst_init_done", 64'(init_done), 64'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_csb0", 64'(csb0), 64'd0);
        checkOutput("midrst_addr0", 64'(addr0), 64'd0);
        tick();
        checkOutput("midrst_rsp_after", 64'(rsp_valid), 64'b00);
        checkOutput("midrst_addr0_step", 64'(addr0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule

// File: doc/sram_rw_scheduler.md
SRAM_RW_SCHEDULER -- requirements
Module: sram_rw_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning SRAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, meaning SRAM address width; depth is 2**ADDR_WIDTH.
REQ-003 SHALL have these ports, one per line:
  clk0  in  1  single clock for both SRAM ports
  rst_n  in  1  synchronous, active-low reset
  wr_valid  in  1  write request
  wr_addr  in  ADDR_WIDTH  write address
  wr_data  in  DATA_WIDTH  write data
  wr_ready  out  1  write accepted this cycle
  rd_valid  in  2  read requests from requesters 0 and 1
  rd_addr  in  2*ADDR_WIDTH  read addresses; requester i is slice [i*ADDR_WIDTH +: ADDR_WIDTH]
  rd_ready  out  2  read accepted, one-hot
  rsp_valid  out  2  read data valid, one-hot
  rsp_data  out  DATA_WIDTH  read data
  init_done  out  1  memory clear complete
  csb0, addr0, din0  out  1/ADDR_WIDTH/DATA_WIDTH  SRAM write port, csb0 active low
  csb1, addr1  out  1/ADDR_WIDTH  SRAM read port, csb1 active low
  dout1  in  DATA_WIDTH  SRAM read data
REQ-004 SHALL use one clock with a synchronous, active-low reset; clk0 and rst_n are the clock and reset port names, and clk0 drives both SRAM clock pins.

Function
REQ-005 SHALL implement FSM states INIT and RUN, and SHALL enter INIT on reset.
REQ-006 In INIT, SHALL write zero to addresses 0 through 2**ADDR_WIDTH-1, one address per cycle, incrementing addr0.
REQ-007 In INIT, SHALL hold wr_ready=0 and rd_ready=0.
REQ-008 SHALL move INIT->RUN in the cycle after the write to the last address, and SHALL set init_done=1 from then until the next reset.
REQ-009 In RUN, SHALL drive wr_ready=1 unconditionally, so a write is accepted on any cycle with wr_valid=1.
REQ-010 An accepted write SHALL drive csb0=0, addr0=wr_addr and din0=wr_data in the same cycle; otherwise csb0=1.
REQ-011 SHALL pick at most one read per cycle using round-robin over the 2 requesters; after a grant to requester i, requester 1-i has priority.
REQ-012 A granted read SHALL drive csb1=0 and addr1=rd_addr[i]; otherwise csb1=1.
REQ-013 A granted read SHALL assert rsp_valid[i] for exactly one cycle, 2 cycles after the grant.
REQ-014 The cycle with rsp_valid[i] asserted SHALL have rsp_data equal to dout1, registered on the posedge following the SRAM negedge read.
REQ-015 rsp_data SHALL hold its previous value while rsp_valid=0.
REQ-016 Collision: when the read candidate address equals the address of a write accepted in the same cycle, SHALL withhold the read grant for that cycle (rd_ready=0) and keep round-robin priority unchanged; the write proceeds.
REQ-017 SHALL accept back-to-back reads every cycle, with no more than 2 responses outstanding.
REQ-018 Address values SHALL wrap only through the ADDR_WIDTH truncation; the INIT counter stops at its maximum value and does not wrap.

Reset
REQ-019 While rst_n=0 at a clk0 posedge, SHALL reset the outputs to: csb0=1, csb1=1, wr_ready=0, rd_ready=0, rsp_valid=0, rsp_data=0, init_done=0, INIT counter=0.
REQ-020 Reset during INIT or RUN SHALL discard in-flight responses (no rsp_valid afterwards) and restart INIT at address 0.

Configuration
REQ-021 With SRAM_SCHED_FWD_EN defined, a collision SHALL NOT stall the read; the read is granted and rsp_data is the colliding wr_data, with the same 2-cycle latency.
REQ-022 Without SRAM_SCHED_FWD_EN defined, collisions SHALL stall the read as in REQ-016.

Structure
REQ-023 The shared package sram_sched_pkg SHALL contain the FSM state enum (INIT, RUN) and the default width constants.
REQ-024 SHALL contain one sub-module, sram_rr_arb2, the 2-way round-robin arbiter.

Verification
REQ-025 Bench SHALL cover reset release: init_done rises exactly 513 cycles after rst_n goes high (512 zero writes plus one cycle for the INIT->RUN transition), and all 512 addresses then read back as 0.
REQ-026 Bench SHALL cover write then read: write 0xDEADBEEF to 0x05, read 0x05 from requester 0 the next cycle -> rsp_valid=2'b01 two cycles after the grant, with rsp_data=0xDEADBEEF.
REQ-027 Bench SHALL cover fairness: both requesters hold rd_valid=1 for 4 cycles -> grants alternate 0,1,0,1.
REQ-028 Bench SHALL cover collision: write 0x12345678 to 0x1FF and read 0x1FF in the same cycle -> without the macro, rd_ready=0 that cycle and the read is granted next cycle returning 0x12345678; with the macro, the read is granted immediately returning 0x12345678.
REQ-029 Bench SHALL cover reset mid-read: assert rst_n=0 one cycle after a grant -> no rsp_valid, and INIT restarts at address 0.
